dec_countdown: RTL and testbench

- Sequential decrement unit for the datapath component library: the down-direction counterpart of the increment component.
- Two functions:
  - Single-step mode: registered d - 1 with wrap and borrow flag.
  - Countdown mode: loads a start value and decrements to zero under an enable, with a start/busy/done handshake.
- Used by scheduled datapaths and controllers for loop counts and delay timers.

---
 rtl/dec_countdown.sv | 81 ++++++++
 tb/tb_dec_countdown.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/dec_countdown.sv
// Sequential decrement unit: registered single-step d - 1 with borrow, or a
// start/busy/done countdown from a loaded value to zero under an enable.
module dec_countdown #(
    parameter int unsigned DATAWIDTH = 8
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [DATAWIDTH-1:0] a,
    input  logic                 start,
    input  logic                 en,
    input  logic                 step,
    output logic [DATAWIDTH-1:0] d,
    output logic                 busy,
    output logic                 done,
    output logic                 zero,
    output logic                 borrow
);

    localparam logic [DATAWIDTH-1:0] one = DATAWIDTH'(1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t state;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state  <= StIdle;
            d      <= '0;
            zero   <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b0;
            borrow <= 1'b0;
        end else begin
            // done and borrow are single-cycle pulses unless re-asserted below
            done   <= 1'b0;
            borrow <= 1'b0;
            case (state)
                StIdle: begin
                    if (start) begin
                        if (a != '0) begin
                            d     <= a;
                            zero  <= 1'b0;
                            busy  <= 1'b1;
                            state <= StRun;
                        end else begin
                            d     <= '0;
                            zero  <= 1'b1;
                            done  <= 1'b1;
                            state <= StDone;
                        end
                    end else if (step) begin
                        d      <= d - one;
                        zero   <= (d == one);
                        borrow <= (d == '0);
                    end
                end
                StRun: begin
                    if (en) begin
                        if (d > one) begin
                            d <= d - one;
                        end else begin
                            // countdown never goes below zero
                            d     <= '0;
                            zero  <= 1'b1;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= StDone;
                        end
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dec_countdown.sv
// Self-checking bench for dec_countdown: directed vector table, two hand-written
// multi-cycle sequences, then random stimulus against an arithmetic reference model.
module tb_dec_countdown;

    logic       Clk;
    logic       Rst;
    logic [7:0] a;
    logic       start;
    logic       en;
    logic       step;
    logic [7:0] d;
    logic       busy;
    logic       done;
    logic       zero;
    logic       borrow;

    int checks = 0;
    int errors = 0;

    // reference model: plain integer count plus a mode number
    int m_d      = 0;
    int m_mode   = 0;  // 0 idle, 1 counting, 2 finished-pulse cycle
    int m_done   = 0;
    int m_borrow = 0;

    dec_countdown #(.DATAWIDTH(8)) dut (
        .Clk    (Clk),
        .Rst    (Rst),
        .a      (a),
        .start  (start),
        .en     (en),
        .step   (step),
        .d      (d),
        .busy   (busy),
        .done   (done),
        .zero   (zero),
        .borrow (borrow)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic       rst;
        logic       start;
        logic       en;
        logic       step;
        logic [7:0] a;
        logic [7:0] ed;
        logic       ebusy;
        logic       edone;
        logic       ezero;
        logic       eborrow;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, s, e, st, input logic [7:0] av,
                                input logic [7:0] xd, input logic xb, xdn, xz, xbr);
        vec_t v;
        v.rst = r; v.start = s; v.en = e; v.step = st; v.a = av;
        v.ed = xd; v.ebusy = xb; v.edone = xdn; v.ezero = xz; v.eborrow = xbr;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input logic r, s, e, st, input logic [7:0] av);
        if (r) begin
            m_d = 0; m_mode = 0; m_done = 0; m_borrow = 0;
        end else begin
            m_done = 0;
            m_borrow = 0;
            if (m_mode == 0) begin
                if (s) begin
                    if (av != 0) begin
                        m_d = av; m_mode = 1;
                    end else begin
                        m_d = 0; m_mode = 2; m_done = 1;
                    end
                end else if (st) begin
                    m_borrow = (m_d == 0);
                    m_d = (m_d + 255) % 256;
                end
            end else if (m_mode == 1) begin
                if (e) begin
                    m_d = m_d - 1;
                    if (m_d == 0) begin
                        m_mode = 2; m_done = 1;
                    end
                end
            end else begin
                m_mode = 0;
            end
        end
    endtask

    // drive inputs, take one rising edge, sample 1 time unit later
    task automatic tick(input logic r, s, e, st, input logic [7:0] av);
        Rst = r; start = s; en = e; step = st; a = av;
        @(posedge Clk);
        #1;
        model_update(r, s, e, st, av);
    endtask

    task automatic chk_outs(input string tag, input int xd, xb, xdn, xz, xbr);
        chk({tag, ".d"}, d, xd);
        chk({tag, ".busy"}, busy, xb);
        chk({tag, ".done"}, done, xdn);
        chk({tag, ".zero"}, zero, xz);
        chk({tag, ".borrow"}, borrow, xbr);
    endtask

    initial begin
        Rst = 1'b1; start = 1'b0; en = 1'b0; step = 1'b0; a = 8'd0;

        // reset, countdown from 3
        vecs.push_back(mk(1, 0, 0, 0, 8'd0, 8'd0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 8'd0, 8'd0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 1, 0, 8'd3, 8'd3, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 8'd0, 8'd2, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 8'd0, 8'd1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 8'd0, 8'd0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 8'd0, 8'd0, 0, 0, 1, 0));
        // step wrap from 0, then plain step, then hold
        vecs.push_back(mk(0, 0, 0, 1, 8'd0, 8'hFF, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 8'd0, 8'hFE, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 8'd0, 8'hFE, 0, 0, 0, 0));
        // start with a == 0 goes straight to done
        vecs.push_back(mk(0, 1, 0, 0, 8'd0, 8'd0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 8'd0, 8'd0, 0, 0, 1, 0));
        // start/step ignored during RUN and DONE
        vecs.push_back(mk(0, 1, 1, 0, 8'd4, 8'd4, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 8'd9, 8'd3, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 8'd9, 8'd2, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 8'd0, 8'd1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 8'd0, 8'd0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 1, 0, 1, 8'd9, 8'd0, 0, 0, 1, 0));
        // start beats step in IDLE
        vecs.push_back(mk(0, 1, 0, 1, 8'd2, 8'd2, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 8'd0, 8'd2, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 8'd0, 8'd1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 8'd0, 8'd0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 8'd0, 8'd0, 0, 0, 1, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            tick(vecs[i].rst, vecs[i].start, vecs[i].en, vecs[i].step, vecs[i].a);
            chk_outs($sformatf("vec%0d", i), vecs[i].ed, vecs[i].ebusy, vecs[i].edone,
                     vecs[i].ezero, vecs[i].eborrow);
        end

        // en toggling: a=5 finishes on the 5th enabled edge (edge 9)
        tick(0, 1, 1, 0, 8'd5);
        chk_outs("tog_e0", 5, 1, 0, 0, 0);
        for (int k = 1; k <= 9; k++) begin
            int xd;
            xd = 5 - (k + 1) / 2;
            tick(0, 0, logic'(k % 2), 0, 8'd0);
            chk_outs($sformatf("tog_e%0d", k), xd, (k < 9) ? 1 : 0, (k == 9) ? 1 : 0,
                     (xd == 0) ? 1 : 0, 0);
        end
        tick(0, 0, 0, 0, 8'd0);
        chk_outs("tog_after", 0, 0, 0, 1, 0);

        // reset mid-countdown, then a fresh countdown of 2
        tick(0, 1, 1, 0, 8'd10);
        chk_outs("rst_e0", 10, 1, 0, 0, 0);
        for (int k = 1; k <= 4; k++) begin
            tick(0, 0, 1, 0, 8'd0);
            chk_outs($sformatf("rst_e%0d", k), 10 - k, 1, 0, 0, 0);
        end
        tick(1, 0, 1, 0, 8'd0);
        chk_outs("rst_mid", 0, 0, 0, 1, 0);
        tick(0, 1, 1, 0, 8'd2);
        chk_outs("rst_new0", 2, 1, 0, 0, 0);
        tick(0, 0, 1, 0, 8'd0);
        chk_outs("rst_new1", 1, 1, 0, 0, 0);
        tick(0, 0, 1, 0, 8'd0);
        chk_outs("rst_new2", 0, 0, 1, 1, 0);

        // random stimulus against the model
        tick(1, 0, 0, 0, 8'd0);
        chk_outs("rnd_rst", m_d, (m_mode == 1) ? 1 : 0, m_done, (m_d == 0) ? 1 : 0, m_borrow);
        for (int n = 0; n < 3000; n++) begin
            logic       r, s, e, st;
            logic [7:0] av;
            r  = ($urandom_range(0, 99) < 2);
            s  = ($urandom_range(0, 99) < 20);
            e  = ($urandom_range(0, 99) < 70);
            st = ($urandom_range(0, 99) < 35);
            case ($urandom_range(0, 7))
                0:       av = 8'd0;
                1:       av = 8'($urandom_range(0, 255));
                default: av = 8'($urandom_range(1, 12));
            endcase
            tick(r, s, e, st, av);
            chk_outs($sformatf("rnd%0d", n), m_d, (m_mode == 1) ? 1 : 0, m_done,
                     (m_d == 0) ? 1 : 0, m_borrow);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
